// File: rtl/scan_pkg.sv
// Shared types and constants for the scan test controller.
// Imported by the interface, the phase counter and the top.
package scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } scan_state_t;

  localparam int FAIL_CNT_W = 8;
  localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_MAX = 8'd255;

  // Bits needed to hold a phase length minus one.
  function automatic int cnt_width(int a, int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/scan_ctrl_if.sv
// Request/result and scan-port bundle of scan_ctrl.
// master: pattern source plus chain; slave: the controller.
interface scan_ctrl_if
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 4
);
  logic                  start;
  logic [CHAIN_LEN-1:0]  pattern;
  logic [CHAIN_LEN-1:0]  expected;
  logic [CHAIN_LEN-1:0]  mask;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CHAIN_LEN-1:0]  response;
  logic [FAIL_CNT_W-1:0] fail_cnt;
  logic                  SE;
  logic                  scan_in;
  logic                  scan_out;

  modport master (
    output start, pattern, expected, mask,
    output scan_out,
    input  busy, done, pass, response,
    input  fail_cnt, SE, scan_in
  );

  modport slave (
    input  start, pattern, expected, mask,
    input  scan_out,
    output busy, done, pass, response,
    output fail_cnt, SE, scan_in
  );
endinterface

// File: rtl/scan_phase_cnt.sv
// Loadable down-counter timing each scan phase.
// tc_o is high once the count has reached zero.
module scan_phase_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/scan_ctrl.sv
// Scan test controller: shift-in, capture, shift-out, compare.
// Drives SE/scan_in from registers; samples scan_out in SHIFT_OUT.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN      = 4,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  scan_ctrl_if.slave  bus
);

  localparam int CW = cnt_width(CHAIN_LEN, CAPTURE_CYCLES);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(CAPTURE_CYCLES - 1);

  localparam int N = CHAIN_LEN;

  scan_state_t state_q, state_d;
  logic se_q, se_d;
  logic sin_q, sin_d;
  logic [N-1:0] sh_q, sh_d;
  logic [N-1:0] exp_q, exp_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] resp_q, resp_d;
  logic pass_q, pass_d;
  logic [FAIL_CNT_W-1:0] fail_q, fail_d;
  logic cnt_load;
  logic [CW-1:0] cnt_val;
  logic tc;

  scan_phase_cnt #(
    .W(CW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load_i(cnt_load),
    .val_i (cnt_val),
    .tc_o  (tc)
  );

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    exp_d    = exp_q;
    mask_d   = mask_q;
    resp_d   = resp_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    cnt_load = 1'b0;
    cnt_val  = SHIFT_LAST;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_SHIFT_IN;
          sh_d     = bus.pattern;
          exp_d    = bus.expected;
          mask_d   = bus.mask;
          resp_d   = '0;
          pass_d   = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = SHIFT_LAST;
        end
      end
      S_SHIFT_IN: begin
        if (tc) begin
          state_d  = S_CAPTURE;
          cnt_load = 1'b1;
          cnt_val  = CAP_LAST;
        end else begin
          sh_d = {sh_q[N-2:0], 1'b0};
        end
      end
      S_CAPTURE: begin
        if (tc) begin
          state_d  = S_SHIFT_OUT;
          cnt_load = 1'b1;
          cnt_val  = SHIFT_LAST;
        end
      end
      S_SHIFT_OUT: begin
        resp_d = {resp_q[N-2:0], bus.scan_out};
        if (tc) begin
          state_d = S_DONE;
          pass_d  = (((resp_d ^ exp_q) & mask_q) == '0);
          if (!pass_d && fail_q != FAIL_CNT_MAX) begin
            fail_d = fail_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scan port is registered, so it follows the state being entered.
  assign se_d  = (state_d == S_SHIFT_IN) ||
                 (state_d == S_SHIFT_OUT);
  assign sin_d = (state_d == S_SHIFT_IN) & sh_d[N-1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      se_q    <= 1'b0;
      sin_q   <= 1'b0;
      sh_q    <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      resp_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      se_q    <= se_d;
      sin_q   <= sin_d;
      sh_q    <= sh_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      resp_q  <= resp_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.SE       = se_q;
  assign bus.scan_in  = sin_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.pass     = pass_q;
  assign bus.response = resp_q;
  assign bus.fail_cnt = fail_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl driving a 4-bit scan-enabled counter model.
// Expected results come from counter arithmetic, not the RTL.
module tb_scan_ctrl;

  localparam int N = 4;
  localparam int CAP = 1;
  localparam int DONE_AT = 2 * N + CAP + 1;

  logic clk;
  logic reset;
  int checks;
  int errors;
  int fc_model;
  logic [N-1:0] chain = '0;

  scan_ctrl_if #(.CHAIN_LEN(N)) bus ();

  scan_ctrl #(
    .CHAIN_LEN     (N),
    .CAPTURE_CYCLES(CAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Chain under test: shifts when SE=1, counts up otherwise.
  always @(posedge clk) begin
    if (bus.SE) chain <= {chain[N-2:0], bus.scan_in};
    else chain <= chain + 4'd1;
  end
  assign bus.scan_out = chain[N-1];

  function automatic logic [N-1:0] model_resp(logic [N-1:0] p);
    return 4'((int'(p) + CAP) % 16);
  endfunction

  function automatic logic model_pass(logic [N-1:0] p,
                                      logic [N-1:0] e,
                                      logic [N-1:0] m);
    return ((model_resp(p) ^ e) & m) == 4'd0;
  endfunction

  task automatic model_account(input logic ok);
    if (!ok && fc_model < 255) fc_model++;
  endtask

  task automatic run_one(input logic [N-1:0] p,
                         input logic [N-1:0] e,
                         input logic [N-1:0] m,
                         output int dcyc,
                         output logic ps,
                         output logic [N-1:0] rsp,
                         output logic [7:0] fc);
    bus.pattern = p;
    bus.expected = e;
    bus.mask = m;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dcyc = -1;
    ps = 1'b0;
    rsp = '0;
    fc = '0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done) begin
        dcyc = c;
        ps = bus.pass;
        rsp = bus.response;
        fc = bus.fail_cnt;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.pattern = '0;
    bus.expected = '0;
    bus.mask = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.SE !== 1'b0 || bus.scan_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_scan: SE=%b scan_in=%b want 0 0",
               bus.SE, bus.scan_in);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b want 0 0",
               bus.busy, bus.done);
    end
    checks++;
    if (bus.fail_cnt !== 8'd0 || bus.response !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs: fail_cnt=%0d resp=%b want 0 0",
               bus.fail_cnt, bus.response);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] pv;
    int nd;
    int dc;
    pv = 4'b1010;
    nd = 0;
    dc = -1;
    bus.pattern = pv;
    bus.expected = 4'b1011;
    bus.mask = 4'b1111;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    model_account(model_pass(pv, 4'b1011, 4'b1111));
    for (int c = 1; c <= 12; c++) begin
      if (c <= N) begin
        checks++;
        if (bus.SE !== 1'b1 || bus.scan_in !== pv[N-c]) begin
          errors++;
          $display("FAIL basic_shift%0d: SE=%b sin=%b want 1 %b",
                   c, bus.SE, bus.scan_in, pv[N-c]);
        end
      end
      if (c == N + 1) begin
        checks++;
        if (bus.SE !== 1'b0) begin
          errors++;
          $display("FAIL basic_capture_se: SE=%b want 0", bus.SE);
        end
      end
      if (bus.done === 1'b1) begin
        nd++;
        if (dc < 0) dc = c;
        checks++;
        if (bus.response !== model_resp(pv) ||
            bus.pass !== 1'b1 ||
            bus.fail_cnt !== 8'(fc_model)) begin
          errors++;
          $display("FAIL basic_result: resp=%b pass=%b fc=%0d want %b 1 %0d",
                   bus.response, bus.pass, bus.fail_cnt,
                   model_resp(pv), fc_model);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (nd !== 1 || dc !== DONE_AT) begin
      errors++;
      $display("FAIL basic_done: count=%0d cycle=%0d want 1 %0d",
               nd, dc, DONE_AT);
    end
  endtask

  task automatic test_mask();
    int dc;
    logic ps;
    logic [N-1:0] rsp;
    logic [7:0] fc;
    run_one(4'b1010, 4'b1111, 4'b0100, dc, ps, rsp, fc);
    model_account(model_pass(4'b1010, 4'b1111, 4'b0100));
    checks++;
    if (dc !== DONE_AT || ps !== 1'b0 || rsp !== 4'b1011) begin
      errors++;
      $display("FAIL mask_0100: done@%0d pass=%b resp=%b want %0d 0 1011",
               dc, ps, rsp, DONE_AT);
    end
    run_one(4'b1010, 4'b1111, 4'b1010, dc, ps, rsp, fc);
    model_account(model_pass(4'b1010, 4'b1111, 4'b1010));
    checks++;
    if (dc !== DONE_AT || ps !== 1'b1 || fc !== 8'(fc_model)) begin
      errors++;
      $display("FAIL mask_1010: done@%0d pass=%b fc=%0d want %0d 1 %0d",
               dc, ps, fc, DONE_AT, fc_model);
    end
  endtask

  task automatic test_fail_count();
    int dc;
    logic ps;
    logic [N-1:0] rsp;
    logic [N-1:0] p;
    logic [N-1:0] e;
    logic [N-1:0] m;
    logic [7:0] fc;
    logic exp_ps;
    int b;
    run_one(4'b1010, 4'b1100, 4'b1111, dc, ps, rsp, fc);
    model_account(model_pass(4'b1010, 4'b1100, 4'b1111));
    checks++;
    if (ps !== 1'b0 || fc !== 8'(fc_model)) begin
      errors++;
      $display("FAIL fail_first: pass=%b fc=%0d want 0 %0d",
               ps, fc, fc_model);
    end
    for (int i = 0; i < 300; i++) begin
      p = 4'($urandom_range(15));
      if (i < 40) begin
        e = 4'($urandom_range(15));
        m = 4'($urandom_range(15));
      end else begin
        b = int'($urandom_range(N - 1));
        m = 4'($urandom_range(15)) | 4'(1 << b);
        e = model_resp(p) ^ 4'(1 << b);
      end
      exp_ps = model_pass(p, e, m);
      model_account(exp_ps);
      run_one(p, e, m, dc, ps, rsp, fc);
      checks++;
      if (dc !== DONE_AT || ps !== exp_ps ||
          rsp !== model_resp(p) || fc !== 8'(fc_model)) begin
        errors++;
        $display("FAIL rand%0d: done@%0d pass=%b resp=%b fc=%0d want %0d %b %b %0d",
                 i, dc, ps, rsp, fc, DONE_AT, exp_ps,
                 model_resp(p), fc_model);
      end
    end
    checks++;
    if (bus.fail_cnt !== 8'd255) begin
      errors++;
      $display("FAIL fail_saturate: fc=%0d want 255", bus.fail_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int nd;
    int dc;
    logic bz;
    nd = 0;
    dc = -1;
    bz = 1'b1;
    bus.pattern = 4'b0011;
    bus.expected = 4'b0100;
    bus.mask = 4'b1111;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    model_account(model_pass(4'b0011, 4'b0100, 4'b1111));
    for (int c = 1; c <= 14; c++) begin
      bus.start = (c == 3);
      if (bus.done === 1'b1) begin
        nd++;
        if (dc < 0) dc = c;
      end
      if (c == 12) bz = bus.busy;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    checks++;
    if (nd !== 1 || dc !== DONE_AT) begin
      errors++;
      $display("FAIL start_ignored: count=%0d cycle=%0d want 1 %0d",
               nd, dc, DONE_AT);
    end
    checks++;
    if (bz !== 1'b0) begin
      errors++;
      $display("FAIL start_not_queued: busy=%b want 0", bz);
    end
  endtask

  task automatic test_back_to_back();
    int nd;
    int d0;
    int d1;
    nd = 0;
    d0 = -1;
    d1 = -1;
    bus.pattern = 4'b0111;
    bus.expected = 4'b1000;
    bus.mask = 4'b1111;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 24; c++) begin
      if (c == 12) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        nd++;
        if (d0 < 0) d0 = c;
        else if (d1 < 0) d1 = c;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    model_account(model_pass(4'b0111, 4'b1000, 4'b1111));
    model_account(model_pass(4'b0111, 4'b1000, 4'b1111));
    checks++;
    if (nd !== 2 || d0 !== DONE_AT || d1 !== 2 * DONE_AT + 1) begin
      errors++;
      $display("FAIL back_to_back: count=%0d at %0d,%0d want 2 at %0d,%0d",
               nd, d0, d1, DONE_AT, 2 * DONE_AT + 1);
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    int dc;
    logic ps;
    logic [N-1:0] rsp;
    logic [7:0] fc;
    nd = 0;
    bus.pattern = 4'b1010;
    bus.expected = 4'b0000;
    bus.mask = 4'b1111;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 6; c++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    fc_model = 0;
    checks++;
    if (bus.SE !== 1'b0 || bus.busy !== 1'b0 ||
        bus.response !== 4'd0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: SE=%b busy=%b resp=%b done=%b want 0 0 0000 0",
               bus.SE, bus.busy, bus.response, bus.done);
    end
    checks++;
    if (bus.fail_cnt !== 8'd0 || bus.pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_regs: fc=%0d pass=%b want 0 0",
               bus.fail_cnt, bus.pass);
    end
    for (int c = 0; c < 12; c++) begin
      if (bus.done === 1'b1) nd++;
      @(posedge clk); #1;
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL reset_mid_nodone: count=%0d want 0", nd);
    end
    run_one(4'b0110, 4'b0111, 4'b1111, dc, ps, rsp, fc);
    model_account(model_pass(4'b0110, 4'b0111, 4'b1111));
    checks++;
    if (dc !== DONE_AT || ps !== 1'b1 || rsp !== 4'b0111 ||
        fc !== 8'(fc_model)) begin
      errors++;
      $display("FAIL reset_recover: done@%0d pass=%b resp=%b fc=%0d want %0d 1 0111 %0d",
               dc, ps, rsp, fc, DONE_AT, fc_model);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    fc_model = 0;
    test_reset();
    test_basic();
    test_mask();
    test_start_ignored();
    test_back_to_back();
    test_fail_count();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
# scan_ctrl

On-chip scan test controller that drives the scan port (`SE`, `scan_in`) of the 4-bit scan-enabled counter and consumes its `scan_out`. Per test it shifts a pattern into the chain, runs a programmable number of functional capture clocks, shifts the response back out and compares it against an expected value. It sits directly upstream of the counter's scan port and downstream of whatever supplies patterns (bench or BIST sequencer). It turns the hand-timed scan stimulus of the counter bench into a reusable, cycle-exact block.

## Interface
- `CHAIN_LEN`, default 4: scan chain length in flops; legal range 2..32.
- `CAPTURE_CYCLES`, default 1: functional clocks with `SE`=0 between shift-in and shift-out; legal range 1..15.

- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-low reset (0 = reset), sampled on the rising edge of `clk`.
- `start`  input  1: request a test; accepted only in IDLE.
- `pattern`  input  CHAIN_LEN: value to load into the chain; bit CHAIN_LEN-1 is shifted first.
- `expected`  input  CHAIN_LEN: expected captured chain contents.
- `mask`  input  CHAIN_LEN: 1 = compare this bit, 0 = don't-care.
- `scan_out`  input  1: serial output of the chain, carrying chain bit CHAIN_LEN-1.
- `SE`  output  1: scan enable to the chain (registered).
- `scan_in`  output  1: serial data to the chain, entering chain bit 0 (registered).
- `busy`  output  1: high from the cycle after `start` acceptance through the DONE cycle.
- `done`  output  1: one-cycle pulse in the DONE state.
- `pass`  output  1: result of the last test; valid when `done`=1 and held until the next acceptance.
- `response`  output  CHAIN_LEN: captured chain contents of the last test.
- `fail_cnt`  output  8: count of failed tests, saturating at 255.

## Operation
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE: `SE`=0, `scan_in`=0. When `start`=1, latch `pattern`, `expected` and `mask`, clear `response`, and go to SHIFT_IN.
- SHIFT_IN: lasts CHAIN_LEN cycles. `SE`=1. In shift cycle k (0-based), `scan_in` = pattern[CHAIN_LEN-1-k]. Then go to CAPTURE.
- CAPTURE: lasts CAPTURE_CYCLES cycles. `SE`=0, `scan_in`=0. Then go to SHIFT_OUT.
- SHIFT_OUT: lasts CHAIN_LEN cycles. `SE`=1, `scan_in`=0 (fill).
  - On every edge ending a SHIFT_OUT cycle, update `response <= {response[CHAIN_LEN-2:0], scan_out}`.
  - After the final sample, `response` equals the post-capture chain contents.
- DONE: one cycle.
  - `done`=1.
  - `pass` = ((response ^ expected_latched) & mask_latched) == 0.
  - If the test failed and `fail_cnt`<255, increment `fail_cnt`.
  - Next state is IDLE.
- `start` outside IDLE is ignored and not queued. `start` held high re-triggers on the cycle after DONE.
- A single cycle counter (width sufficient for max(CHAIN_LEN, CAPTURE_CYCLES)) times each phase. It is cleared on every state entry.
- Reset (any state, mid-shift included):
  - state = IDLE; `SE`=0, `scan_in`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `response`=0, `fail_cnt`=0.
  - The chain contents are left undefined; no recovery shift.

## Timing
- Acceptance edge: T0. `SE`/`scan_in` for shift cycle 0 are valid in cycle T0+1.
- SHIFT_IN occupies cycles T0+1 .. T0+CHAIN_LEN.
- CAPTURE occupies the next CAPTURE_CYCLES cycles.
- SHIFT_OUT occupies the next CHAIN_LEN cycles.
- `done` is high in cycle T0 + 2·CHAIN_LEN + CAPTURE_CYCLES + 1. With the defaults this is T0+10.
- `scan_out` is sampled on the same edge on which the chain shifts. The chain must present bit CHAIN_LEN-1 combinationally from its flop.
- `pass`, `response` and `fail_cnt` update on the edge entering DONE and remain stable until the next acceptance (or reset).

## Structure
- Package `scan_pkg`: state enum typedef `scan_state_t` (5 states), `FAIL_CNT_W`=8, `FAIL_CNT_MAX`=255.
- One sub-module, `scan_phase_cnt`: a loadable down-counter with a terminal-count flag that sequences phase lengths. The FSM and the response shift register live in `scan_ctrl`.

## Test plan
- Reset, then idle 5 cycles → `SE`=0, `scan_in`=0, `busy`=0, `done`=0, `fail_cnt`=0.
- Defaults, chain = the 4-bit counter, pattern=1010, expected=1011, mask=1111 → `scan_in` sequence 1,0,1,0 on T0+1..T0+4; `SE`=0 in T0+5; `response`=1011, `pass`=1, `done` at T0+10.
- Same test with expected=1100 → `pass`=0 and `fail_cnt`=1. Repeat 300 times → `fail_cnt` saturates at 255.
- expected=1111, mask=0100 against response 1011 → `pass`=0. Then mask=1010 → `pass`=1.
- `start` pulsed at T0+3 during SHIFT_IN → ignored, with a single `done` at T0+10. `start` held high → second acceptance on the cycle after DONE.
- `reset` driven low at T0+6 (in SHIFT_OUT) → next cycle `SE`=0, `busy`=0, `response`=0, with no `done` pulse. A new `start` then completes a normal test.
